// File: rtl/issue_scheduler_pkg.sv
// rtl/issue_scheduler_pkg.sv - shared types, constants and mask helper for the issue scheduler
package issue_scheduler_pkg;

  localparam int ISS_NREGS = 32;
  localparam int ISS_RID_W = 5;

  typedef enum logic [1:0] {
    CLS_ALU    = 2'd0,
    CLS_MEM    = 2'd1,
    CLS_BRANCH = 2'd2,
    CLS_NOP    = 2'd3
  } slot_class_e;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_WAIT     = 2'd1,
    ST_REDIRECT = 2'd2
  } state_e;

  // One-hot register mask; id 0 means "no register" and maps to an empty mask.
  function automatic logic [ISS_NREGS-1:0] rid_to_mask(input logic [ISS_RID_W-1:0] id);
    logic [ISS_NREGS-1:0] m;
    m = '0;
    if (id != '0) m[id] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/issue_scheduler_sb_file.sv
// rtl/issue_scheduler_sb_file.sv - register scoreboard with set-over-clear priority
module issue_scheduler_sb_file
  import issue_scheduler_pkg::*;
#(
  parameter int NREGS = ISS_NREGS
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NREGS-1:0] set_mask,
  input  logic [NREGS-1:0] clr_mask,
  output logic [NREGS-1:0] sb_busy
);

  logic [NREGS-1:0] sb_d;
  logic [NREGS-1:0] sb_q;

  // Next scoreboard: a set in the same cycle as a clear wins; bit 0 never tracked.
  always_comb begin
    sb_d = (sb_q & ~clr_mask) | set_mask;
    sb_d[0] = 1'b0;
  end

  // Scoreboard register.
  always_ff @(posedge clk) begin
    if (reset) sb_q <= '0;
    else       sb_q <= sb_d;
  end

  assign sb_busy = sb_q;

endmodule

// File: rtl/issue_scheduler.sv
// rtl/issue_scheduler.sv - in-order dispatch of the hazard-free decode prefix with redirect sequencing
module issue_scheduler
  import issue_scheduler_pkg::*;
#(
  parameter int SCALE   = 2,
  parameter int NREGS   = ISS_NREGS,
  parameter int RID_W   = ISS_RID_W,
  parameter int CNT_W   = $clog2(SCALE + 1),
  parameter int MSLOT_W = (SCALE > 1) ? $clog2(SCALE) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [SCALE-1:0]         slot_valid,
  input  logic [2*SCALE-1:0]       slot_class,
  input  logic [RID_W*SCALE-1:0]   slot_dst,
  input  logic [RID_W*SCALE-1:0]   slot_src0,
  input  logic [RID_W*SCALE-1:0]   slot_src1,
  input  logic [SCALE-1:0]         slot_br_taken,
  input  logic [64*SCALE-1:0]      slot_br_target,
  input  logic                     mem_busy,
  input  logic                     fetch_idle,
  input  logic [SCALE:0]           wb_valid,
  input  logic [RID_W*(SCALE+1)-1:0] wb_dst,
  output logic [CNT_W-1:0]         deq_slots,
  output logic [SCALE-1:0]         alu_issue,
  output logic                     mem_issue,
  output logic [MSLOT_W-1:0]       mem_issue_slot,
  output logic                     redirect_valid,
  output logic [63:0]              redirect_pc,
  output logic [NREGS-1:0]         sb_busy,
  output logic [31:0]              issued_total,
  output logic [31:0]              stall_cycles
);

  localparam logic [1:0] S_RUN      = 2'(ST_RUN);
  localparam logic [1:0] S_WAIT     = 2'(ST_WAIT);
  localparam logic [1:0] S_REDIRECT = 2'(ST_REDIRECT);

  logic [1:0]       state_d, state_q;
  logic [63:0]      redirect_pc_d, redirect_pc_q;
  logic [31:0]      issued_total_d, issued_total_q;
  logic [31:0]      stall_cycles_d, stall_cycles_q;

  logic [NREGS-1:0] set_mask;
  logic [NREGS-1:0] clr_mask;
  logic [NREGS-1:0] run_mask;
  logic [NREGS-1:0] use_mask;
  logic             scan_stop;
  logic             mem_used;
  logic             blocked;
  logic             br_taken_hit;
  logic [63:0]      br_target;

  // Prefix scan: walk slots in order, issue until the first invalid or blocked slot
  // or a taken branch. Hazards see only registered busy bits plus earlier issues this cycle.
  always_comb begin
    deq_slots      = '0;
    alu_issue      = '0;
    mem_issue      = 1'b0;
    mem_issue_slot = '0;
    set_mask       = '0;
    run_mask       = sb_busy;
    use_mask       = '0;
    scan_stop      = 1'b0;
    mem_used       = 1'b0;
    blocked        = 1'b0;
    br_taken_hit   = 1'b0;
    br_target      = '0;
    if (!reset && state_q == S_RUN) begin
      for (int i = 0; i < SCALE; i++) begin
        if (!scan_stop) begin
          if (!slot_valid[i]) begin
            scan_stop = 1'b1;
          end else begin
            use_mask = rid_to_mask(slot_src0[i*RID_W +: RID_W])
                     | rid_to_mask(slot_src1[i*RID_W +: RID_W])
                     | rid_to_mask(slot_dst[i*RID_W +: RID_W]);
            blocked = (use_mask & run_mask) != '0;
            if (slot_class_e'(slot_class[2*i +: 2]) == CLS_MEM && (mem_busy || mem_used))
              blocked = 1'b1;
            if (blocked) begin
              scan_stop = 1'b1;
            end else begin
              deq_slots = deq_slots + CNT_W'(1);
              case (slot_class_e'(slot_class[2*i +: 2]))
                CLS_ALU: begin
                  alu_issue[i] = 1'b1;
                  set_mask     = set_mask | rid_to_mask(slot_dst[i*RID_W +: RID_W]);
                  run_mask     = run_mask | rid_to_mask(slot_dst[i*RID_W +: RID_W]);
                end
                CLS_MEM: begin
                  mem_issue      = 1'b1;
                  mem_used       = 1'b1;
                  mem_issue_slot = MSLOT_W'(i);
                  set_mask       = set_mask | rid_to_mask(slot_dst[i*RID_W +: RID_W]);
                  run_mask       = run_mask | rid_to_mask(slot_dst[i*RID_W +: RID_W]);
                end
                CLS_BRANCH: begin
                  if (slot_br_taken[i]) begin
                    br_taken_hit = 1'b1;
                    br_target    = slot_br_target[64*i +: 64];
                    scan_stop    = 1'b1;
                  end
                end
                default: ;
              endcase
            end
          end
        end
      end
    end
  end

  // Writeback clears from every lane; id 0 contributes nothing.
  always_comb begin
    clr_mask = '0;
    for (int j = 0; j <= SCALE; j++) begin
      if (wb_valid[j]) clr_mask = clr_mask | rid_to_mask(wb_dst[j*RID_W +: RID_W]);
    end
  end

  // Redirect FSM and counters; reset abandons any pending redirect.
  always_comb begin
    state_d        = state_q;
    redirect_pc_d  = redirect_pc_q;
    issued_total_d = issued_total_q + 32'(deq_slots);
    stall_cycles_d = stall_cycles_q;
    if (state_q == S_RUN && slot_valid[0] && deq_slots == '0 && stall_cycles_q != 32'hFFFF_FFFF)
      stall_cycles_d = stall_cycles_q + 32'd1;
    case (state_q)
      S_RUN: begin
        if (br_taken_hit) begin
          redirect_pc_d = br_target;
          state_d       = fetch_idle ? S_REDIRECT : S_WAIT;
        end
      end
      S_WAIT:     if (fetch_idle) state_d = S_REDIRECT;
      S_REDIRECT: state_d = S_RUN;
      default:    state_d = S_RUN;
    endcase
  end

  // Control state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_RUN;
      redirect_pc_q  <= '0;
      issued_total_q <= '0;
      stall_cycles_q <= '0;
    end else begin
      state_q        <= state_d;
      redirect_pc_q  <= redirect_pc_d;
      issued_total_q <= issued_total_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  issue_scheduler_sb_file #(.NREGS(NREGS)) u_sb (
    .clk      (clk),
    .reset    (reset),
    .set_mask (set_mask),
    .clr_mask (clr_mask),
    .sb_busy  (sb_busy)
  );

  assign redirect_valid = !reset && state_q == S_REDIRECT;
  assign redirect_pc    = redirect_pc_q;
  assign issued_total   = issued_total_q;
  assign stall_cycles   = stall_cycles_q;

endmodule
